display_scheduler: RTL and testbench

- Owns the four 7-segment digit registers and shares them between two requesters: the CPU OUT instruction path and the switch-input echo path.
- Arbitrates, latches one 16-bit value, and converts it to BCD sequentially (shift-and-add-3, one bit per cycle).
- Decodes the four BCD digits and updates all four display registers atomically.
- Sits between the core's I/O stage and the board's seven-segment pins.

---
 rtl/display_scheduler_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 22 ++
 rtl/display_scheduler.sv | 173 +++++++++++++++++
 tb/tb_display_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared constants and types for the display scheduler: FSM encoding,
// blank/dash segment patterns and the BCD-to-segment lookup table.
// Segments are active-low, bit0=a .. bit6=g.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  // Indices 10..15 are not valid BCD; they decode to blank.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (combinational).
// Ports:
//   bcd   - 4-bit BCD digit
//   blank - force all segments off
//   seg_c - segment pattern, bit0=a .. bit6=g, active-low
module seg7_decode
  import display_scheduler_pkg::*;
(
  input  logic [3:0]       bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup; blank overrides the digit.
  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      seg_c = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Display scheduler: arbitrates between the CPU OUT path and the switch
// echo path, converts the accepted binary value to BCD with a sequential
// shift-and-add-3, then updates all four seven-segment registers at once.
// Ports:
//   clock, reset         - rising-edge clock, async active-low reset
//   out_req/out_data     - CPU request (level) and value, low WIDTH bits used
//   in_req/in_data       - echo request (level) and switch value
//   out_ack/in_ack       - one-cycle acceptance pulses
//   busy                 - conversion in flight
//   ovf                  - last committed value exceeded 9999 (sticky)
//   R1..R4               - units..thousands segments, active-low
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             out_req,
  input  logic [31:0]      out_data,
  input  logic             in_req,
  input  logic [15:0]      in_data,
  output logic             out_ack,
  output logic             in_ack,
  output logic             busy,
  output logic             ovf,
  output logic [SEG_W-1:0] R1,
  output logic [SEG_W-1:0] R2,
  output logic [SEG_W-1:0] R3,
  output logic [SEG_W-1:0] R4
);

  // One spare nibble above the displayed digits catches values > 9999.
  localparam int unsigned BCD_NIB = DIGITS + 1;
  localparam int unsigned BCD_W   = 4 * BCD_NIB;
  localparam int unsigned SR_W    = BCD_W + WIDTH;
  localparam int unsigned CNT_W   = $clog2(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic               take_out_c;
  logic               take_in_c;

  logic [SR_W-1:0]    sr_q;
  logic [SR_W-1:0]    sr_step_c;
  logic [CNT_W-1:0]   cnt_q;

  logic [3:0]         digit_c [DIGITS];
  logic [DIGITS-1:0]  blank_c;
  logic               lead_zero_c;
  logic [SEG_W-1:0]   seg_c   [DIGITS];
  logic [SEG_W-1:0]   seg_q   [DIGITS];
  logic               ovf_c;

  logic               unused_c;
  assign unused_c = ^out_data[31:WIDTH];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request grant; CPU has fixed priority over echo.
  always_comb begin
    state_d    = state_q;
    take_out_c = 1'b0;
    take_in_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (out_req) begin
          take_out_c = 1'b1;
          state_d    = ST_CONV;
        end else if (in_req) begin
          take_in_c = 1'b1;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Add-3 correction on every BCD nibble >= 5, ahead of the shift.
  always_comb begin
    sr_step_c = sr_q;
    for (int i = 0; i < int'(BCD_NIB); i++) begin
      if (sr_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_step_c[WIDTH + 4*i +: 4] = sr_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit extraction and decoders.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    assign digit_c[g] = sr_q[WIDTH + 4*g +: 4];

    seg7_decode u_dec (
      .bcd   (digit_c[g]),
      .blank (blank_c[g]),
      .seg_c (seg_c[g])
    );
  end

  // Leading-zero blanking, scanning from the most significant digit;
  // the units digit always shows.
  always_comb begin
    blank_c     = '0;
    lead_zero_c = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lead_zero_c = lead_zero_c && (digit_c[i] == 4'd0);
      blank_c[i]  = (BLANK_LEADING != 0) && lead_zero_c && (i != 0);
    end
  end

  assign ovf_c = (sr_q[SR_W-1 -: 4] != 4'd0);

  // Datapath, handshake and display registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      out_ack <= 1'b0;
      in_ack  <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        seg_q[i] <= SEG_BLANK;
      end
    end else begin
      out_ack <= take_out_c;
      in_ack  <= take_in_c;
      busy    <= (state_d != ST_IDLE);
      if (take_out_c) begin
        sr_q  <= {BCD_W'(0), out_data[WIDTH-1:0]};
        cnt_q <= '0;
        ovf   <= 1'b0;
      end else if (take_in_c) begin
        sr_q  <= {BCD_W'(0), WIDTH'(in_data)};
        cnt_q <= '0;
        ovf   <= 1'b0;
      end else if (state_q == ST_CONV) begin
        sr_q  <= {sr_step_c[SR_W-2:0], 1'b0};
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == ST_COMMIT) begin
        ovf <= ovf_c;
        for (int i = 0; i < int'(DIGITS); i++) begin
          seg_q[i] <= ovf_c ? SEG_DASH : seg_c[i];
        end
      end
    end
  end

  assign R1 = seg_q[0];
  assign R2 = seg_q[1];
  assign R3 = seg_q[2];
  assign R4 = seg_q[3];

endmodule

// File: tb/tb_display_scheduler.sv
// Testbench for display_scheduler: table of single requests with expected
// segment patterns, plus sequences for arbitration, held requests and reset.
module tb_display_scheduler;

  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    bit          cpu;
    logic [31:0] data;
    logic [6:0]  r4, r3, r2, r1;
    logic        ovf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        out_req = 1'b0;
  logic [31:0] out_data = '0;
  logic        in_req = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ack, in_ack, busy, ovf;
  logic [6:0]  R1, R2, R3, R4;

  int checks = 0;
  int failures = 0;

  vec_t vecs [10];

  display_scheduler dut (
    .clock    (clock),
    .reset    (reset),
    .out_req  (out_req),
    .out_data (out_data),
    .in_req   (in_req),
    .in_data  (in_data),
    .out_ack  (out_ack),
    .in_ack   (in_ack),
    .busy     (busy),
    .ovf      (ovf),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3),
    .R4       (R4)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request from IDLE; checks ack edge, quiet busy window, commit at k+17.
  task automatic do_vec(input int idx);
    logic [27:0] snap;
    bit          stable;
    vec_t        v;
    v = vecs[idx];
    @(negedge clock);
    snap = {R4, R3, R2, R1};
    if (v.cpu) begin
      out_req  = 1'b1;
      out_data = v.data;
    end else begin
      in_req  = 1'b1;
      in_data = v.data[15:0];
    end
    @(negedge clock);
    check($sformatf("v%0d_ack", idx), {29'd0, out_ack, in_ack, busy},
          v.cpu ? 32'd5 : 32'd3);
    out_req = 1'b0;
    in_req  = 1'b0;
    stable  = 1'b1;
    repeat (16) begin
      @(negedge clock);
      if (busy !== 1'b1 || out_ack !== 1'b0 || in_ack !== 1'b0 ||
          {R4, R3, R2, R1} !== snap) stable = 1'b0;
    end
    check($sformatf("v%0d_stable", idx), {31'd0, stable}, 32'd1);
    @(negedge clock);
    check($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_segs", idx), {4'd0, R4, R3, R2, R1},
          {4'd0, v.r4, v.r3, v.r2, v.r1});
    check($sformatf("v%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.ovf});
  endtask

  initial begin
    bit flag;
    logic [27:0] snap;

    vecs[0] = '{1'b1, 32'h0000_04D2, S1, S2, S3, S4, 1'b0};
    vecs[1] = '{1'b0, 32'd7,         SB, SB, SB, S7, 1'b0};
    vecs[2] = '{1'b0, 32'd0,         SB, SB, SB, S0, 1'b0};
    vecs[3] = '{1'b1, 32'd10000,     SD, SD, SD, SD, 1'b1};
    vecs[4] = '{1'b1, 32'hABCD_0005, SB, SB, SB, S5, 1'b0};
    vecs[5] = '{1'b0, 32'd9999,      S9, S9, S9, S9, 1'b0};
    vecs[6] = '{1'b1, 32'd100,       SB, S1, S0, S0, 1'b0};
    vecs[7] = '{1'b0, 32'd1010,      S1, S0, S1, S0, 1'b0};
    vecs[8] = '{1'b1, 32'd9,         SB, SB, SB, S9, 1'b0};
    vecs[9] = '{1'b1, 32'd65535,     SD, SD, SD, SD, 1'b1};

    // Power-on reset.
    repeat (3) @(negedge clock);
    check("rst_segs", {4'd0, R4, R3, R2, R1}, {4'd0, SB, SB, SB, SB});
    check("rst_ctl", {28'd0, out_ack, in_ack, busy, ovf}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) do_vec(i);

    // Simultaneous requests: CPU 42 first, echo 9000 at k+18.
    @(negedge clock);
    out_req = 1'b1; out_data = 32'd42;
    in_req  = 1'b1; in_data  = 16'd9000;
    @(negedge clock);
    check("sim_cpu_ack", {29'd0, out_ack, in_ack, busy}, 32'd5);
    out_req = 1'b0;
    flag = 1'b1;
    repeat (16) begin
      @(negedge clock);
      if (in_ack !== 1'b0 || busy !== 1'b1) flag = 1'b0;
    end
    check("sim_echo_waits", {31'd0, flag}, 32'd1);
    @(negedge clock);
    check("sim_42_segs", {4'd0, R4, R3, R2, R1}, {4'd0, SB, SB, S4, S2});
    check("sim_k17_ctl", {29'd0, out_ack, in_ack, busy}, 32'd0);
    @(negedge clock);
    check("sim_echo_ack", {29'd0, out_ack, in_ack, busy}, 32'd3);
    in_req = 1'b0;
    repeat (16) @(negedge clock);
    @(negedge clock);
    check("sim_9000_segs", {4'd0, R4, R3, R2, R1}, {4'd0, S9, S0, S0, S0});

    // Request held through busy: re-served only after busy falls.
    @(negedge clock);
    out_req = 1'b1; out_data = 32'd1234;
    @(negedge clock);
    check("hold_ack1", {29'd0, out_ack, in_ack, busy}, 32'd5);
    flag = 1'b1;
    repeat (16) begin
      @(negedge clock);
      if (out_ack !== 1'b0 || {R4, R3, R2, R1} !== {S9, S0, S0, S0}) flag = 1'b0;
    end
    check("hold_no_ack", {31'd0, flag}, 32'd1);
    @(negedge clock);
    check("hold_commit", {4'd0, R4, R3, R2, R1}, {4'd0, S1, S2, S3, S4});
    check("hold_k17_ctl", {30'd0, out_ack, busy}, 32'd0);
    @(negedge clock);
    check("hold_ack2", {30'd0, out_ack, busy}, 32'd3);
    out_req = 1'b0;
    flag = 1'b1;
    repeat (17) begin
      @(negedge clock);
      if ({R4, R3, R2, R1} !== {S1, S2, S3, S4} || out_ack !== 1'b0) flag = 1'b0;
    end
    check("hold_no_tear", {31'd0, flag}, 32'd1);
    check("hold_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clock);
    out_req = 1'b1; out_data = 32'd77;
    @(negedge clock);
    check("rstmid_ack", {29'd0, out_ack, in_ack, busy}, 32'd5);
    out_req = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rstmid_segs", {4'd0, R4, R3, R2, R1}, {4'd0, SB, SB, SB, SB});
    check("rstmid_ctl", {28'd0, out_ack, in_ack, busy, ovf}, 32'd0);
    flag = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if ({R4, R3, R2, R1} !== {SB, SB, SB, SB} || {out_ack, in_ack, busy, ovf} !== 4'd0)
        flag = 1'b0;
    end
    check("rstmid_held", {31'd0, flag}, 32'd1);
    reset = 1'b1;
    snap  = {SB, SB, SB, SB};
    flag  = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if ({R4, R3, R2, R1} !== snap || {out_ack, in_ack, busy, ovf} !== 4'd0)
        flag = 1'b0;
    end
    check("rst_release_idle", {31'd0, flag}, 32'd1);

    // Normal operation after reset.
    do_vec(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
